cla_bist_ctrl: RTL and testbench

CLA_BIST_CTRL -- requirements
Module: cla_bist_ctrl

---
 rtl/cla_bist_ctrl.sv | 116 +++++++++++
 tb/tb_cla_bist_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_bist_ctrl.sv
// Exhaustive self-test controller for a registered 4-bit adder: issues all 512
// {cin, b, a} vectors, checks the delayed results and reports the first failure and the error count.
module cla_bist_ctrl #(
    parameter int unsigned DUT_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_cin,
    input  logic [3:0] dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [8:0]         drv_vec;
    logic [4:0]         pipe_exp [DUT_LAT];
    logic [8:0]         pipe_idx [DUT_LAT];
    logic [DUT_LAT-1:0] pipe_vld;
    logic               start_run;
    logic               last_vec;
    logic               cmp_vld;
    logic               mismatch;
    logic               last_cmp;

    // The vector register doubles as the operand drivers: {cin, b, a} = index.
    assign {dut_cin, dut_b, dut_a} = drv_vec;

    assign start_run = start && (state == IDLE || state == DONE);
    assign last_vec  = (state == RUN) && (drv_vec == 9'd511);
    assign cmp_vld   = pipe_vld[DUT_LAT-1];
    // Case inequality so an X/Z response never compares equal.
    assign mismatch  = cmp_vld && ({dut_cout, dut_sum} !== pipe_exp[DUT_LAT-1]);
    assign last_cmp  = cmp_vld && (pipe_idx[DUT_LAT-1] == 9'd511);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_run) state_nxt = RUN;
            RUN:     if (last_vec)  state_nxt = DRAIN;
            DRAIN:   if (last_cmp)  state_nxt = DONE;
            DONE:    if (start_run) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_vec          <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (start_run) begin
            drv_vec          <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (state == RUN) begin
                drv_vec <= last_vec ? '0 : drv_vec + 9'd1;
            end
            if (mismatch) begin
                err_count <= err_count + 10'd1;
                if (!first_fail_valid) begin
                    first_fail_vec   <= pipe_idx[DUT_LAT-1];
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

    // Expected-result pipeline, aligned with the adder's own latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < DUT_LAT; i++) begin
                pipe_exp[i] <= '0;
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= (state == RUN);
            pipe_exp[0] <= {1'b0, dut_a} + {1'b0, dut_b} + {4'b0000, dut_cin};
            pipe_idx[0] <= drv_vec;
            for (int unsigned i = 1; i < DUT_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cla_bist_ctrl.sv
// Bench for cla_bist_ctrl: three instances (latency 2, 1, 4) each wired to a
// registered adder model; the latency-2 model can be faulted.
module tb_cla_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [3];
    logic [3:0] a [3];
    logic [3:0] b [3];
    logic       cin [3];
    logic [3:0] s [3];
    logic       co [3];
    logic       bsy [3];
    logic       dn [3];
    logic       ps [3];
    logic [9:0] ec [3];
    logic [8:0] ffv [3];
    logic       ffval [3];

    int fault = 0;
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cla_bist_ctrl #(.DUT_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .dut_a(a[0]), .dut_b(b[0]), .dut_cin(cin[0]),
        .dut_sum(s[0]), .dut_cout(co[0]),
        .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
        .err_count(ec[0]), .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0])
    );

    cla_bist_ctrl #(.DUT_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .dut_a(a[1]), .dut_b(b[1]), .dut_cin(cin[1]),
        .dut_sum(s[1]), .dut_cout(co[1]),
        .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
        .err_count(ec[1]), .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1])
    );

    cla_bist_ctrl #(.DUT_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .dut_a(a[2]), .dut_b(b[2]), .dut_cin(cin[2]),
        .dut_sum(s[2]), .dut_cout(co[2]),
        .busy(bsy[2]), .done(dn[2]), .pass(ps[2]),
        .err_count(ec[2]), .first_fail_vec(ffv[2]), .first_fail_valid(ffval[2])
    );

    function automatic logic [4:0] add5(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    // Registered adder models.
    logic [4:0] m2 [2];
    logic [4:0] m1 [1];
    logic [4:0] m4 [4];
    logic [4:0] r2;

    always @(posedge clk) begin
        m2[0] <= add5(a[0], b[0], cin[0]);
        m2[1] <= m2[0];
        m1[0] <= add5(a[1], b[1], cin[1]);
        m4[0] <= add5(a[2], b[2], cin[2]);
        for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
    end

    // Fault modes: 1 sum[0]=0, 2 cout=0, 3 cout=1, 4 sum=0000.
    always_comb begin
        r2 = m2[1];
        case (fault)
            1: r2[0] = 1'b0;
            2: r2[4] = 1'b0;
            3: r2[4] = 1'b1;
            4: r2[3:0] = 4'b0000;
            default: ;
        endcase
    end

    assign {co[0], s[0]} = r2;
    assign {co[1], s[1]} = m1[0];
    assign {co[2], s[2]} = m4[3];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name, input int w);
        check({name, "/busy"}, int'(bsy[w]), 0);
        check({name, "/done"}, int'(dn[w]), 0);
        check({name, "/pass"}, int'(ps[w]), 0);
        check({name, "/err_count"}, int'(ec[w]), 0);
        check({name, "/ffv"}, int'(ffv[w]), 0);
        check({name, "/ffvalid"}, int'(ffval[w]), 0);
        check({name, "/operands"}, int'({cin[w], b[w], a[w]}), 0);
    endtask

    typedef struct {
        string name;
        int    which;
        int    flt;
        int    restart_at;
        int    cycles;
        int    pass_exp;
        int    err_exp;
        int    ffv_exp;
        int    ffvalid_exp;
    } vec_t;

    vec_t tbl [8];

    task automatic run_vec(input vec_t v);
        int cyc;
        int busy_n;
        fault = v.flt;
        @(negedge clk);
        start[v.which] = 1'b1;
        @(posedge clk);
        #1;
        start[v.which] = 1'b0;
        check({v.name, "/start_busy"}, int'(bsy[v.which]), 1);
        check({v.name, "/start_done"}, int'(dn[v.which]), 0);
        check({v.name, "/start_err_clr"}, int'(ec[v.which]), 0);
        check({v.name, "/start_ffvalid_clr"}, int'(ffval[v.which]), 0);
        cyc = 0;
        busy_n = 0;
        while (!dn[v.which] && cyc < 2000) begin
            if (bsy[v.which]) busy_n++;
            if (cyc == 37 || cyc == 300)
                check($sformatf("%s/vec%0d", v.name, cyc), int'({cin[v.which], b[v.which], a[v.which]}), cyc);
            if (cyc == v.restart_at) start[v.which] = 1'b1;
            @(posedge clk);
            #1;
            start[v.which] = 1'b0;
            cyc++;
        end
        check({v.name, "/done_cycle"}, cyc, v.cycles);
        check({v.name, "/busy_cycles"}, busy_n, v.cycles);
        check({v.name, "/done"}, int'(dn[v.which]), 1);
        check({v.name, "/pass"}, int'(ps[v.which]), v.pass_exp);
        check({v.name, "/err_count"}, int'(ec[v.which]), v.err_exp);
        check({v.name, "/ffvalid"}, int'(ffval[v.which]), v.ffvalid_exp);
        if (v.ffvalid_exp != 0)
            check({v.name, "/ffv"}, int'(ffv[v.which]), v.ffv_exp);
        check({v.name, "/operands_idle"}, int'({cin[v.which], b[v.which], a[v.which]}), 0);
        repeat (3) @(posedge clk);
        #1;
        check({v.name, "/done_held"}, int'(dn[v.which]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"clean",      0, 0,  -1, 514, 1,   0,  0, 0};
        tbl[1] = '{"sum0_stuck", 0, 1,  -1, 514, 0, 256,  1, 1};
        tbl[2] = '{"cout_low",   0, 2,  -1, 514, 0, 256, 31, 1};
        tbl[3] = '{"cout_high",  0, 3,  -1, 514, 0, 256,  0, 1};
        tbl[4] = '{"sum_zero",   0, 4,  -1, 514, 0, 480,  1, 1};
        tbl[5] = '{"restart",    0, 0, 100, 514, 1,   0,  0, 0};
        tbl[6] = '{"lat1",       1, 0,  -1, 513, 1,   0,  0, 0};
        tbl[7] = '{"lat4",       2, 0,  -1, 516, 1,   0,  0, 0};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) check_idle_outputs($sformatf("reset%0d", i), i);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a faulty run.
        fault = 1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_busy", int'(bsy[0]), 0);
        check("post_reset_done", int'(dn[0]), 0);
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_no_cmp", int'(ec[0]), 0);
        check("post_reset_still_idle", int'(bsy[0]), 0);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
